apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
- Synthesizable APB slave model sitting directly downstream of the AHB-to-APB bridge; consumes Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata.
- Implements three independent 32-bit register banks, one per Pselx bit.
- Tracks APB phases (IDLE/SETUP/ACCESS) and flags protocol violations.
- Replaces the passive APB stub in the top-level bench so that write-then-read traffic through the bridge is checked end to end.

Parameters:
- DEPTH, 16, words per bank; power of two, 2..256.
- IDX_LSB, 2, lowest Paddr bit of the word index (word-aligned addressing).
- RST_VAL, 32'h0000_0000, reset value of every bank word.

Ports:
- Hclk  input  1  single clock, shared with the bridge; all state updates on rising edge.
- Hresetn  input  1  asynchronous active-low reset.
- Pselx  input  3  one-hot slave select; bit k selects bank k.
- Penable  input  1  APB access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; bits [IDX_LSB+log2(DEPTH)-1:IDX_LSB] form the word index.
- Pwdata  input  32  write data.
- Prdata  output  32  read data, registered.
- proto_err  output  1  sticky protocol-violation flag.
- err_count  output  8  saturating count of violations.

Behaviour:
- Reset (async, Hresetn=0):
  - Prdata=0, proto_err=0, err_count=0, FSM=IDLE.
  - All bank words = RST_VAL.
  - A reset asserted mid-transfer aborts the transfer; no partial write commits.
- Phase FSM, evaluated each rising edge:
  - IDLE -> SETUP when Pselx!=0 and Penable=0.
  - SETUP -> ACCESS when Penable=1.
  - ACCESS -> SETUP when Pselx!=0 and Penable=0 (back-to-back transfer).
  - ACCESS -> IDLE when Pselx=0.
  - ACCESS with Penable=1 held for a second cycle: stays ACCESS and counts as a violation.
- Setup capture: in SETUP, latch Pselx, Pwrite and the word index into sel_q/wr_q/idx_q.
- Read timing:
  - On the edge that enters SETUP with Pwrite=0, Prdata <= bank[sel][idx].
  - Prdata is therefore stable through the whole ACCESS cycle, so the bridge samples it without wait states.
  - Zero wait states; no PREADY.
- Read-after-write: a write committed in cycle N is visible to a read whose setup is in cycle N+1 or later.
- Write commit:
  - On the edge where FSM=ACCESS, Penable=1, Pwrite=1 and there is no violation: bank[sel_q][idx_q] <= Pwdata.
  - Exactly one write per transfer, including when Penable is held.
- Prdata hold: unchanged except at a read setup. Write transfers do not disturb it.
- Out-of-range index (DEPTH not full address field): unused upper Paddr bits are ignored. Index wraps modulo DEPTH, e.g. DEPTH=16 and Paddr=0x40 -> word 0.
- Violations (each counted once per offending cycle):
  - (a) Pselx not one-hot and not zero.
  - (b) Penable=1 while FSM=IDLE.
  - (c) In ACCESS, Pselx, Pwrite or the word index differs from the latched value.
  - (d) Penable=1 in ACCESS for a second consecutive cycle.
- On a violation:
  - proto_err <= 1 (sticky until reset); err_count increments, saturating at 8'hFF.
  - A violating transfer does not write. For (a), Prdata <= 0.
  - After (b) the FSM stays IDLE.
- Simultaneous events: a violation and a counter saturation in the same cycle -> count stays 0xFF, flag set.

Decomposition:
- Shared package apb_pkg holds:
  - the phase enum IDLE/SETUP/ACCESS;
  - slot constants SEL_S0=3'b001, SEL_S1=3'b010, SEL_S2=3'b100;
  - bridge address-map bases 0x8000_0000, 0x8400_0000, 0x8800_0000.
- One natural sub-module, apb_bank_mem: DEPTH x 32 register array with one write port and one synchronous read port. Instantiated three times.
- The FSM, checker and Prdata mux stay in the top.

Test Plan:
- Reset mid-write: assert Hresetn=0 during ACCESS of a write of 0xDEAD_BEEF to S0 word 3 -> Prdata=0, proto_err=0, word 3 reads back 0.
- Write 0x1234_5678 to S1 word 5 (Paddr=0x8400_0014), then read the same address -> Prdata=0x1234_5678 during the ACCESS cycle; S0 and S2 word 5 read 0.
- Back-to-back: write S2 word 0 = 0xA5A5_A5A5, immediately followed by read S2 word 0 with no IDLE between -> read returns 0xA5A5_A5A5, FSM goes ACCESS -> SETUP -> ACCESS.
- Illegal select: Pselx=3'b011 setup + access with Pwrite=1, Pwdata=0xFFFF_FFFF -> proto_err=1, err_count=2 (setup and access cycles), no bank modified, Prdata=0.
- Control change: setup write at S0 word 1, flip Pwrite to 0 in ACCESS -> err_count=1, word 1 unchanged.
- Saturation: inject 260 Penable-in-IDLE cycles -> err_count=0xFF, proto_err=1, FSM remains IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: phase encoding, slot selects and the bridge
// address map used by the register-bank slave and its bench.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_phase_t;

    localparam int unsigned NUM_SLOTS = 3;

    localparam logic [2:0] SEL_S0 = 3'b001;
    localparam logic [2:0] SEL_S1 = 3'b010;
    localparam logic [2:0] SEL_S2 = 3'b100;

    localparam logic [31:0] BASE_S0 = 32'h8000_0000;
    localparam logic [31:0] BASE_S1 = 32'h8400_0000;
    localparam logic [31:0] BASE_S2 = 32'h8800_0000;

    // More than one select bit set at once.
    function automatic logic sel_illegal(input logic [2:0] sel);
        return (sel != '0) && ((sel & (sel - 3'd1)) != '0);
    endfunction

endpackage

// File: rtl/apb_bank_mem.sv
// One DEPTH x 32 register bank: single write port, single registered read
// port whose output holds until the next read enable.
module apb_bank_mem #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IW      = $clog2(DEPTH),
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[wr_idx] <= wdata;
            end
            if (re) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with three independent register banks behind the AHB-to-APB
// bridge; tracks transfer phases and counts protocol violations.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IDX_LSB = 2,
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        proto_err,
    output logic [7:0]  err_count
);

    localparam int unsigned IW = $clog2(DEPTH);

    apb_phase_t      state;
    apb_phase_t      state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_q;
    logic [2:0]      sel_q;
    logic            wr_q;
    logic [2:0]      rd_src_q;
    logic            sel_any;
    logic            sel_bad;
    logic            setup_ev;
    logic            access_ev;
    logic            viol;
    logic            commit;
    logic            rd_go;
    logic [2:0]      we;
    logic [2:0]      re;
    logic [31:0]     rd_data [NUM_SLOTS];
    logic            addr_unused;

    // Only the word-index field selects anything; the rest is deliberately ignored.
    assign idx         = Paddr[IDX_LSB +: IW];
    assign addr_unused = ^Paddr;
    assign sel_any     = |Pselx;
    assign sel_bad     = sel_illegal(Pselx);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // state holds the phase of the cycle just completed; the inputs decide the current one.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!Penable && sel_any) state_nxt = SETUP;
            end
            SETUP: begin
                if (Penable)       state_nxt = ACCESS;
                else if (!sel_any) state_nxt = IDLE;
            end
            ACCESS: begin
                if (Penable)      state_nxt = ACCESS;
                else if (sel_any) state_nxt = SETUP;
                else              state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        setup_ev  = (state_nxt == SETUP);
        access_ev = Penable && (state != IDLE);
        viol      = sel_bad
                  || (Penable && (state == IDLE))
                  || (Penable && (state == ACCESS))
                  || (access_ev && ((Pselx != sel_q) || (Pwrite != wr_q) || (idx != idx_q)));
        commit    = access_ev && (state == SETUP) && wr_q && !viol;
        rd_go     = setup_ev && !Pwrite && !viol;
        we        = commit ? sel_q : '0;
        re        = rd_go ? Pselx : '0;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            sel_q     <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            rd_src_q  <= '0;
            proto_err <= 1'b0;
            err_count <= '0;
        end else begin
            if (setup_ev) begin
                sel_q <= Pselx;
                wr_q  <= Pwrite;
                idx_q <= idx;
            end
            if (sel_bad) begin
                rd_src_q <= '0;
            end else if (rd_go) begin
                rd_src_q <= Pselx;
            end
            if (viol) begin
                proto_err <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_bank
        apb_bank_mem #(
            .DEPTH   (DEPTH),
            .IW      (IW),
            .RST_VAL (RST_VAL)
        ) u_mem (
            .clk     (Hclk),
            .rst_n   (Hresetn),
            .we      (we[k]),
            .wr_idx  (idx_q),
            .wdata   (Pwdata),
            .re      (re[k]),
            .rd_idx  (idx),
            .rd_data (rd_data[k])
        );
    end

    // Prdata is the selected bank's read register; an all-zero source reads as 0.
    always_comb begin
        Prdata = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (rd_src_q[k]) Prdata = rd_data[k];
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: directed vector table, hand-written corner
// sequences and randomized transfers against a transaction-level model.
module tb_apb_slave_regbank;
    import apb_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        proto_err;
    logic [7:0]  err_count;

    always #5 Hclk = ~Hclk;

    apb_slave_regbank #(
        .DEPTH   (DEPTH),
        .IDX_LSB (2),
        .RST_VAL (32'h0000_0000)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .proto_err (proto_err),
        .err_count (err_count)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mbank [3][DEPTH];
    logic [31:0] mprdata;
    int          merr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic bus_idle();
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        tick();
    endtask

    // One transfer: setup, access (Prdata sampled there), extra held-Penable cycles.
    task automatic xfer(input logic [2:0] sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int extra, input bit flip,
                        input bit idle_after, output logic [31:0] rd);
        Pselx   = sel;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wd;
        tick();
        Penable = 1'b1;
        if (flip) Pwrite = ~wr;
        rd = Prdata;
        tick();
        repeat (extra) tick();
        if (idle_after) bus_idle();
    endtask

    task automatic do_reset();
        Hresetn = 1'b0;
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        tick();
        Hresetn = 1'b1;
        tick();
        for (int b = 0; b < 3; b++)
            for (int w = 0; w < DEPTH; w++)
                mbank[b][w] = 32'h0;
        mprdata = 32'h0;
        merr    = 0;
    endtask

    initial begin
        vec_t        vecs [9];
        logic [31:0] got;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        wr;
        int          k;
        int          mode;
        int          extra;
        int          w;
        bit          flip;
        bit          idle_after;

        vecs[0] = '{1'b1, SEL_S1, 32'h8400_0014, 32'h1234_5678, 32'h0000_0000};
        vecs[1] = '{1'b0, SEL_S1, 32'h8400_0014, 32'h0000_0000, 32'h1234_5678};
        vecs[2] = '{1'b1, SEL_S0, 32'h8000_0040, 32'hCAFE_0001, 32'h1234_5678};
        vecs[3] = '{1'b0, SEL_S0, 32'h8000_0014, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b0, SEL_S2, 32'h8800_0014, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b0, SEL_S0, 32'h8000_0000, 32'h0000_0000, 32'hCAFE_0001};
        vecs[6] = '{1'b1, SEL_S2, 32'h8800_003C, 32'h0BAD_F00D, 32'hCAFE_0001};
        vecs[7] = '{1'b0, SEL_S2, 32'h8800_007C, 32'h0000_0000, 32'h0BAD_F00D};
        vecs[8] = '{1'b0, SEL_S1, 32'h8400_0010, 32'h0000_0000, 32'h0000_0000};

        Hresetn = 1'b0;
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        repeat (2) tick();
        check("reset_prdata", Prdata, 32'h0);
        check("reset_proto_err", {31'b0, proto_err}, 32'd0);
        check("reset_err_count", {24'b0, err_count}, 32'd0);
        Hresetn = 1'b1;
        tick();

        // Reset mid-write: Prdata cleared, no partial commit, word restored.
        xfer(SEL_S0, 1'b1, BASE_S0 | 32'h0C, 32'h5555_AAAA, 0, 1'b0, 1'b1, got);
        xfer(SEL_S0, 1'b0, BASE_S0 | 32'h0C, 32'h0, 0, 1'b0, 1'b1, got);
        check("pre_reset_read", got, 32'h5555_AAAA);
        Pselx   = SEL_S0;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = BASE_S0 | 32'h0C;
        Pwdata  = 32'hDEAD_BEEF;
        tick();
        Penable = 1'b1;
        #2;
        Hresetn = 1'b0;
        #1;
        check("midrst_prdata", Prdata, 32'h0);
        check("midrst_proto_err", {31'b0, proto_err}, 32'd0);
        tick();
        Pselx   = '0;
        Penable = 1'b0;
        Hresetn = 1'b1;
        tick();
        xfer(SEL_S0, 1'b0, BASE_S0 | 32'h0C, 32'h0, 0, 1'b0, 1'b1, got);
        check("midrst_word3", got, 32'h0);

        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 1'b0, 1'b1, got);
            check($sformatf("vec%0d_prdata", i), got, vecs[i].exp_rd);
        end
        check("vec_err_count", {24'b0, err_count}, 32'd0);

        // Back-to-back write then read of S2 word 0, no idle between.
        xfer(SEL_S2, 1'b1, BASE_S2, 32'hA5A5_A5A5, 0, 1'b0, 1'b0, got);
        xfer(SEL_S2, 1'b0, BASE_S2, 32'h0, 0, 1'b0, 1'b1, got);
        check("b2b_read", got, 32'hA5A5_A5A5);
        check("b2b_err_count", {24'b0, err_count}, 32'd0);

        // Illegal select: two violating cycles, nothing written, Prdata zeroed.
        xfer(3'b011, 1'b1, BASE_S0 | 32'h14, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, got);
        check("illsel_prdata_access", got, 32'h0);
        check("illsel_prdata_after", Prdata, 32'h0);
        check("illsel_proto_err", {31'b0, proto_err}, 32'd1);
        check("illsel_err_count", {24'b0, err_count}, 32'd2);
        xfer(SEL_S0, 1'b0, BASE_S0 | 32'h14, 32'h0, 0, 1'b0, 1'b1, got);
        check("illsel_s0_w5", got, 32'h0);
        xfer(SEL_S1, 1'b0, BASE_S1 | 32'h14, 32'h0, 0, 1'b0, 1'b1, got);
        check("illsel_s1_w5", got, 32'h1234_5678);

        // Pwrite flipped in the access phase.
        xfer(SEL_S0, 1'b1, BASE_S0 | 32'h04, 32'h1111_1111, 0, 1'b1, 1'b1, got);
        check("flip_err_count", {24'b0, err_count}, 32'd3);
        xfer(SEL_S0, 1'b0, BASE_S0 | 32'h04, 32'h0, 0, 1'b0, 1'b1, got);
        check("flip_word1", got, 32'h0);

        // Penable held two extra cycles: two violations, exactly one write.
        xfer(SEL_S1, 1'b1, BASE_S1 | 32'h08, 32'h2222_2222, 2, 1'b0, 1'b1, got);
        check("held_err_count", {24'b0, err_count}, 32'd5);
        xfer(SEL_S1, 1'b0, BASE_S1 | 32'h08, 32'h0, 0, 1'b0, 1'b1, got);
        check("held_word2", got, 32'h2222_2222);

        do_reset();
        for (int n = 0; n < 200; n++) begin
            k          = int'($urandom_range(0, 2));
            sel        = 3'b001 << k;
            addr       = $urandom;
            wd         = $urandom;
            wr         = 1'($urandom_range(0, 1));
            mode       = int'($urandom_range(0, 9));
            w          = int'((addr >> 2) % DEPTH);
            idle_after = ($urandom_range(0, 3) != 0);
            extra      = 0;
            flip       = 1'b0;
            if (mode == 0) begin
                case ($urandom_range(0, 3))
                    0:       sel = 3'b011;
                    1:       sel = 3'b101;
                    2:       sel = 3'b110;
                    default: sel = 3'b111;
                endcase
                mprdata = 32'h0;
                merr    = merr + 2;
            end else begin
                if (mode == 1) begin
                    flip = 1'b1;
                    merr = merr + 1;
                end else if (mode == 2) begin
                    extra = int'($urandom_range(1, 3));
                    merr  = merr + extra;
                end
                if (!wr) mprdata = mbank[k][w];
                else if (mode != 1) mbank[k][w] = wd;
            end
            exp_rd = mprdata;
            xfer(sel, wr, addr, wd, extra, flip, idle_after, got);
            check("rand_prdata", got, exp_rd);
            check("rand_err_count", {24'b0, err_count}, 32'((merr > 255) ? 255 : merr));
            check("rand_proto_err", {31'b0, proto_err}, {31'b0, merr > 0});
        end
        bus_idle();

        // Saturation: Penable asserted while idle, 260 cycles.
        do_reset();
        Pselx   = '0;
        Penable = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 254) check("sat_254", {24'b0, err_count}, 32'd254);
            if (i == 255) check("sat_255", {24'b0, err_count}, 32'd255);
        end
        check("sat_final", {24'b0, err_count}, 32'hFF);
        check("sat_proto_err", {31'b0, proto_err}, 32'd1);
        check("sat_fsm_idle", {31'b0, dut.state == IDLE}, 32'd1);
        bus_idle();
        xfer(SEL_S2, 1'b1, BASE_S2 | 32'h1C, 32'h7777_0007, 0, 1'b0, 1'b1, got);
        xfer(SEL_S2, 1'b0, BASE_S2 | 32'h1C, 32'h0, 0, 1'b0, 1'b1, got);
        check("sat_recover_read", got, 32'h7777_0007);
        check("sat_hold", {24'b0, err_count}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
